// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion: fixed-point gravity with a speed ceiling,
// floor/wall response, X-edge bounce or wrap, out-of-field detection.
module sprite_motion_ctrl #(
    parameter int INITIAL_X       = 32,
    parameter int INITIAL_Y       = 64,
    parameter int INITIAL_X_SPEED = 64,
    parameter int INITIAL_Y_SPEED = 0,
    parameter int GRAVITY         = 4,
    parameter int MAX_Y_SPEED     = 230,
    parameter int FP_SHIFT        = 6,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 575,
    parameter int Y_MAX           = 447,
    parameter int WRAP_X          = 0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               restart,
    input  logic               floorHit,
    input  logic               wallHit,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               onFloor,
    output logic               outOfField
);

    localparam int SCALE = 1 << FP_SHIFT;
    localparam int X0    = INITIAL_X * SCALE;
    localparam int Y0    = INITIAL_Y * SCALE;
    localparam int XMINF = X_MIN * SCALE;
    localparam int XMAXF = X_MAX * SCALE;
    localparam int YMAXF = Y_MAX * SCALE;

    typedef enum logic [1:0] {
        IDLE,
        FALLING,
        ROLLING,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic signed [31:0] r_xpos;
    logic signed [31:0] r_ypos;
    logic signed [31:0] r_xspd;
    logic signed [31:0] r_yspd;
    logic signed [31:0] w_xpos_n;
    logic signed [31:0] w_ypos_n;
    logic signed [31:0] w_xspd_n;
    logic signed [31:0] w_yspd_n;
    logic signed [31:0] w_vx;
    logic signed [31:0] w_vx_abs;
    logic signed [31:0] w_vy_sum;
    logic signed [31:0] w_xsum;
    logic               r_floor_seen;
    logic               r_wall_seen;
    logic               w_floor;
    logic               w_wall;
    logic               w_active;

    assign w_active = (r_state == FALLING) || (r_state == ROLLING);
    // A hit on the strobe cycle itself belongs to the frame being closed
    assign w_floor  = r_floor_seen | floorHit;
    assign w_wall   = r_wall_seen | wallHit;
    assign w_vx_abs = w_vx[31] ? -w_vx : w_vx;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else if (restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_xpos_n  = r_xpos;
        w_ypos_n  = r_ypos;
        w_xspd_n  = r_xspd;
        w_yspd_n  = r_yspd;
        w_vx      = r_xspd;
        w_vy_sum  = '0;
        w_xsum    = '0;
        if (startOfFrame) begin
            case (r_state)
                IDLE: begin
                    if (enable) w_state_n = FALLING;
                end
                FALLING, ROLLING: begin
                    w_vx     = w_wall ? -r_xspd : r_xspd;
                    w_xspd_n = w_vx;
                    if (r_state == FALLING) begin
                        if (w_floor && r_yspd >= 0) begin
                            w_yspd_n  = '0;
                            w_state_n = ROLLING;
                        end else begin
                            w_vy_sum = r_yspd + GRAVITY;
                            w_yspd_n = (w_vy_sum > MAX_Y_SPEED)
                                     ? MAX_Y_SPEED : w_vy_sum;
                        end
                    end else if (!w_floor) begin
                        w_state_n = FALLING;
                    end
                    w_xsum   = r_xpos + w_vx;
                    w_xpos_n = w_xsum;
                    w_ypos_n = r_ypos + w_yspd_n;
                    if (WRAP_X != 0) begin
                        if (w_xsum > XMAXF)      w_xpos_n = XMINF;
                        else if (w_xsum < XMINF) w_xpos_n = XMAXF;
                    end else if (w_xsum < XMINF) begin
                        w_xpos_n = XMINF;
                        w_xspd_n = w_vx_abs;
                    end else if (w_xsum > XMAXF) begin
                        w_xpos_n = XMAXF;
                        w_xspd_n = -w_vx_abs;
                    end
                    if (w_ypos_n >= YMAXF) w_state_n = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_xpos <= X0;
            r_ypos <= Y0;
            r_xspd <= INITIAL_X_SPEED;
            r_yspd <= INITIAL_Y_SPEED;
        end else if (restart) begin
            r_xpos <= X0;
            r_ypos <= Y0;
            r_xspd <= INITIAL_X_SPEED;
            r_yspd <= INITIAL_Y_SPEED;
        end else begin
            r_xpos <= w_xpos_n;
            r_ypos <= w_ypos_n;
            r_xspd <= w_xspd_n;
            r_yspd <= w_yspd_n;
        end
    end

    // Hits outside FALLING/ROLLING are dropped so no stale flag survives
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_floor_seen <= 1'b0;
            r_wall_seen  <= 1'b0;
        end else if (restart || startOfFrame) begin
            r_floor_seen <= 1'b0;
            r_wall_seen  <= 1'b0;
        end else if (w_active) begin
            r_floor_seen <= r_floor_seen | floorHit;
            r_wall_seen  <= r_wall_seen | wallHit;
        end
    end

    assign topLeftX   = 11'(r_xpos >>> FP_SHIFT);
    assign topLeftY   = 11'(r_ypos >>> FP_SHIFT);
    assign onFloor    = (r_state == ROLLING);
    assign outOfField = (r_state == DONE);

endmodule
